// File: rtl/fsk4_crc_framer_pkg.sv
// -----------------------------------------------------------------------------
// crc_fsk_pkg
// Shared types and helpers for the CRC/4FSK transmit framer and the
// receive-side checker.
//   state_t   : framer FSM states (IDLE/CALC/SEND)
//   CRC8_*    : default CRC-8 generator and initial value
//   gray_map  : dibit -> 4FSK frequency index (00->0, 01->1, 11->2, 10->3)
//   cnt_w     : counter width for a modulus n, never narrower than 1 bit
// -----------------------------------------------------------------------------
package crc_fsk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // Gray coding keeps adjacent tones one bit apart.
   function automatic logic [1:0] gray_map(input logic [1:0] dibit);
      return {dibit[1], dibit[1] ^ dibit[0]};
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsk4_crc_framer_crc_serial.sv
// -----------------------------------------------------------------------------
// crc_serial
// Bit-serial MSB-first CRC register (non-reflected, no final XOR).
//   clk, reset : clock, synchronous active-high reset (register -> 0)
//   clear      : load init
//   init       : initial CRC value
//   en         : advance the CRC by one bit (bit_in)
//   bit_in     : message bit
//   crc        : current CRC register
// When clear and en are both high the step is taken from init, so the first
// message bit can be absorbed in the same cycle the register is seeded.
// -----------------------------------------------------------------------------
module crc_serial
   import crc_fsk_pkg::*;
#(
   parameter int               CRC_W = 8,
   parameter logic [CRC_W-1:0] POLY  = CRC8_POLY
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [CRC_W-1:0] init,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] w_base;
   logic [CRC_W-1:0] w_step;
   logic             w_fb;

   always_comb begin
      w_base = clear ? init : r_crc;
      w_fb   = w_base[CRC_W-1] ^ bit_in;
      w_step = {w_base[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
   end

   always_ff @(posedge clk) begin
      if (reset)      r_crc <= '0;
      else if (en)    r_crc <= w_step;
      else if (clear) r_crc <= init;
   end

   assign crc = r_crc;

endmodule

// File: rtl/fsk4_crc_framer.sv
// -----------------------------------------------------------------------------
// fsk4_crc_framer
// Transmit framer: accepts one payload word, computes its CRC bit-serially,
// then sends {payload, crc} (or payload only) MSB-first as Gray-coded 4FSK
// indices, each held SPS clocks.
//   sys_clk, reset : clock, synchronous active-high reset
//   in_data/in_valid/in_crc_en/in_ready : payload handshake (ready in IDLE)
//   sym_idx/sym_valid : symbol index to the tone generator (0 when idle)
//   frame_start/frame_end : first/last cycle of the frame's symbol stream
//   crc_out : CRC of the last completed CALC, busy : state != IDLE
// All outputs come from registers or state decode; none from in_*.
// -----------------------------------------------------------------------------
module fsk4_crc_framer
   import crc_fsk_pkg::*;
#(
   parameter int               DATA_W   = 8,
   parameter int               CRC_W    = 8,
   parameter logic [CRC_W-1:0] POLY     = CRC8_POLY,
   parameter logic [CRC_W-1:0] CRC_INIT = CRC8_INIT,
   parameter int               SPS      = 4
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_crc_en,
   output logic              in_ready,
   output logic [1:0]        sym_idx,
   output logic              sym_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic [CRC_W-1:0]  crc_out,
   output logic              busy
);

   localparam int FRAME_W = DATA_W + CRC_W;
   localparam int BIT_CW  = cnt_w(DATA_W);
   localparam int SYM_CW  = cnt_w(FRAME_W / 2);
   localparam int SPS_CW  = cnt_w(SPS);

   localparam logic [BIT_CW-1:0] LAST_BIT     = BIT_CW'(DATA_W - 1);
   localparam logic [SYM_CW-1:0] LAST_SYM_CRC = SYM_CW'(FRAME_W / 2 - 1);
   localparam logic [SYM_CW-1:0] LAST_SYM_RAW = SYM_CW'(DATA_W / 2 - 1);
   localparam logic [SPS_CW-1:0] LAST_SPS     = SPS_CW'(SPS - 1);

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_data;
   logic                r_crc_en;
   logic [BIT_CW-1:0]   r_bit_cnt;
   logic [FRAME_W-1:0]  r_shift;
   logic [SYM_CW-1:0]   r_sym_cnt;
   logic [SPS_CW-1:0]   r_sps_cnt;
   logic [CRC_W-1:0]    r_crc_out;

   logic                w_accept;
   logic                w_calc_done;
   logic                w_sps_last;
   logic                w_sym_last;
   logic                w_crc_en;
   logic                w_crc_bit;
   logic [BIT_CW-1:0]   w_bit_sel;
   logic [CRC_W-1:0]    w_crc;

   assign w_accept    = (r_state == IDLE) && in_valid;
   assign w_calc_done = (r_state == CALC) && (r_bit_cnt == '0);
   assign w_sps_last  = (r_sps_cnt == LAST_SPS);
   assign w_sym_last  = (r_sym_cnt == (r_crc_en ? LAST_SYM_CRC : LAST_SYM_RAW));

   // The MSB is absorbed on the accept edge, so CALC cycle with count b feeds
   // bit b-1 and the register already holds the final CRC during the last
   // CALC cycle (count 0), ready to be captured into crc_out and the frame.
   assign w_bit_sel = r_bit_cnt - BIT_CW'(1);
   assign w_crc_en  = w_accept || ((r_state == CALC) && (r_bit_cnt != '0));
   assign w_crc_bit = w_accept ? in_data[DATA_W-1] : r_data[w_bit_sel];

   crc_serial #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_crc (
      .clk    (sys_clk),
      .reset  (reset),
      .clear  (w_accept),
      .init   (CRC_INIT),
      .en     (w_crc_en),
      .bit_in (w_crc_bit),
      .crc    (w_crc)
   );

   always_ff @(posedge sys_clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      sym_valid   = 1'b0;
      sym_idx     = 2'd0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (r_bit_cnt == '0) w_state_nxt = SEND;
         end
         SEND: begin
            busy        = 1'b1;
            sym_valid   = 1'b1;
            sym_idx     = gray_map(r_shift[FRAME_W-1 -: 2]);
            frame_start = (r_sym_cnt == '0) && (r_sps_cnt == '0);
            frame_end   = w_sps_last && w_sym_last;
            if (w_sps_last && w_sym_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_data    <= '0;
         r_crc_en  <= 1'b0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_sym_cnt <= '0;
         r_sps_cnt <= '0;
         r_crc_out <= '0;
      end else begin
         if (w_accept) begin
            r_data    <= in_data;
            r_crc_en  <= in_crc_en;
            r_bit_cnt <= LAST_BIT;
         end
         if (r_state == CALC) begin
            r_bit_cnt <= r_bit_cnt - BIT_CW'(1);
            if (w_calc_done) begin
               r_crc_out <= w_crc;
               // Payload-only frames simply stop before the CRC dibits.
               r_shift   <= r_crc_en ? {r_data, w_crc} : {r_data, {CRC_W{1'b0}}};
               r_sym_cnt <= '0;
               r_sps_cnt <= '0;
            end
         end
         if (r_state == SEND) begin
            if (w_sps_last) begin
               r_sps_cnt <= '0;
               r_sym_cnt <= r_sym_cnt + SYM_CW'(1);
               r_shift   <= {r_shift[FRAME_W-3:0], 2'b00};
            end else begin
               r_sps_cnt <= r_sps_cnt + SPS_CW'(1);
            end
         end
      end
   end

   assign crc_out = r_crc_out;

endmodule
